// File: rtl/hazard_ctrl.sv
// ID/EX consumer-side hazard controller: load-use stall, redirect flush,
// destination scoreboard and registered forwarding selects.
module hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_rfwe,
  input  logic            id_is_load,
  input  logic            ex_redirect,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [1:0]      ex_fwd_a,
  output logic [1:0]      ex_fwd_b,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] rd;
    logic            ld;
  } sb_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // index 0 = EX, 1 = MEM, 2 = WB
  sb_t sb [3];
  sb_t id_ent;

  logic       ex_hit1;
  logic       ex_hit2;
  logic       mem_hit1;
  logic       mem_hit2;
  logic       hazard;
  logic       stall;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  assign id_ent.v  = id_valid && id_rfwe && (id_rd != '0);
  assign id_ent.rd = id_rd;
  assign id_ent.ld = id_is_load;

  assign ex_hit1 = id_rs1_used && sb[0].v
                && (id_rs1 == sb[0].rd);
  assign ex_hit2 = id_rs2_used && sb[0].v
                && (id_rs2 == sb[0].rd);
  assign mem_hit1 = id_rs1_used && sb[1].v
                 && (id_rs1 == sb[1].rd);
  assign mem_hit2 = id_rs2_used && sb[1].v
                 && (id_rs2 == sb[1].rd);

  assign hazard = id_valid && sb[0].ld
               && (ex_hit1 || ex_hit2);
  assign stall  = hazard && !ex_redirect;

  // a load in EX is never a forward source; that case stalls instead
  always_comb begin
    fwd_a_d = FWD_RF;
    if (ex_hit1 && !sb[0].ld)
      fwd_a_d = FWD_MEM;
    else if (mem_hit1)
      fwd_a_d = FWD_WB;
  end

  always_comb begin
    fwd_b_d = FWD_RF;
    if (ex_hit2 && !sb[0].ld)
      fwd_b_d = FWD_MEM;
    else if (mem_hit2)
      fwd_b_d = FWD_WB;
  end

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (1'b1)
      ex_redirect: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      stall: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb[0]     <= '0;
      sb[1]     <= '0;
      sb[2]     <= '0;
      ex_fwd_a  <= FWD_RF;
      ex_fwd_b  <= FWD_RF;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      if (id_ex_flush || !id_valid) begin
        sb[0]    <= '0;
        ex_fwd_a <= FWD_RF;
        ex_fwd_b <= FWD_RF;
      end else begin
        sb[0]    <= id_ent;
        ex_fwd_a <= fwd_a_d;
        ex_fwd_b <= fwd_b_d;
      end
      if (stall)
        stall_cnt <= stall_cnt + CNTW'(1);
      if (ex_redirect)
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule
